pc_gen: RTL
===========

# pc_gen

Parametrised fetch program-counter generator; successor to the single-width sequential/predicted/recovered PC register. Sits at the head of the IF stage. It presents one registered fetch address per cycle over a valid/ready handshake, chooses the next address by priority (commit redirect, return-address stack, predictor target, sequential), and optionally keeps a small return-address stack (RAS) for call/return prediction.

## Interface
- `ADDR_W`, 32: fetch address width.
- `INST_BYTES`, 4: sequential step; power of two, at least 1.
- `RESET_PC`, 0: address presented after reset.
- `RAS_DEPTH`, 4: RAS entries; power of two, at least 2; used only with `PC_GEN_RAS_EN`.
- Clock and reset are `clk` and `rst_n`: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; low freezes all state.
- `redirect_valid`  in  1  misprediction or exception recovery from commit.
- `redirect_pc`  in  ADDR_W  recovery target.
- `pred_taken`  in  1  predictor: the instruction at `fetch_pc` is a taken branch.
- `pred_pc`  in  ADDR_W  predictor target.
- `pred_call`  in  1  predecode: the instruction at `fetch_pc` is a call.
- `pred_ret`  in  1  predecode: the instruction at `fetch_pc` is a return.
- `fetch_ready`  in  1  IF accepts `fetch_pc`.
- `fetch_valid`  out  1  `fetch_pc` is valid.
- `fetch_pc`  out  ADDR_W  current fetch address.
- `fetch_src`  out  2  source of `fetch_pc`: 0 = sequential, 1 = predicted, 2 = RAS, 3 = redirect.

## Operation
- Fire = `fetch_valid & fetch_ready`. `pred_*` inputs are sampled only on fire.
- Per rising edge with `rdy` high, first matching case wins:
  1. `redirect_valid`: `fetch_pc` <= `redirect_pc` with the low log2(`INST_BYTES`) bits cleared; `fetch_valid` <= 1; `fetch_src` <= 3; RAS count and pointer cleared. This applies regardless of fire.
  2. `!fetch_valid`: `fetch_valid` <= 1; `fetch_pc` held.
  3. Fire with `pred_ret` and RAS non-empty: next = RAS top; src = 2; pop.
  4. Fire with `pred_taken`: next = `pred_pc`, aligned as in case 1; src = 1.
  5. Fire otherwise: next = `fetch_pc + INST_BYTES`, modulo 2^ADDR_W; src = 0.
  6. No fire: hold all state.
- On fire with `pred_call`: push `fetch_pc + INST_BYTES`, wrapping.
- RAS is circular:
  - Push while full overwrites the oldest entry; count saturates at `RAS_DEPTH`.
  - Pop while empty has no effect; selection falls through to case 4 or 5.
  - `pred_call` and `pred_ret` together: pop first, then push. Net effect: top replaced, count unchanged; next PC is the old top.
- `rdy` low: no state change, and a handshake in that cycle does not count as fire.

## Timing
- Reset values: `fetch_valid` = 0, `fetch_pc` = `RESET_PC`, `fetch_src` = 0, RAS count = 0, RAS pointer = 0.
- First cycle with `rdy` high after reset: `fetch_valid` rises. `RESET_PC` is presented from the next edge onward.
- All outputs are registered; there is no combinational input-to-output path.
- Redirect latency is 1 cycle: the target is on `fetch_pc` at the edge after `redirect_valid`.
- Holding `fetch_ready` low keeps `fetch_pc` and `fetch_src` stable.
- Reset asserted mid-operation clears state immediately, independent of `clk` and `rdy`.

## Configuration
- `PC_GEN_RAS_EN` defined: the RAS is instantiated and behaves as above.
- `PC_GEN_RAS_EN` undefined: no RAS storage exists; `pred_call` and `pred_ret` are ignored; `fetch_src` never takes value 2. All other behaviour is identical.

## Structure
- Shared package `pc_gen_pkg` holds:
  - `fetch_src` encodings `SRC_SEQ`, `SRC_PRED`, `SRC_RAS`, `SRC_REDIR`;
  - the default `INST_BYTES`.
- One sub-module, `pc_ras` (params `ADDR_W`, `RAS_DEPTH`; ports push, pop, clear, wdata, top, empty). It is instantiated only under `PC_GEN_RAS_EN`.

## Test plan
- Reset release with `fetch_ready` = 1, no predictions: `fetch_pc` = 0x0 with `fetch_valid` low, then `fetch_valid` rises, then the sequence 0x0, 0x4, 0x8 follows, `fetch_src` = 0 throughout.
- Fire at 0x100 with `pred_taken` and `pred_pc` = 0x203: next `fetch_pc` = 0x200, src 1. Simultaneous `redirect_valid` with 0x80 instead gives 0x80, src 3.
- `fetch_ready` low for 3 cycles at 0x40: `fetch_pc` stays 0x40. The same hold applies for `rdy` low, even with `fetch_ready` high.
- RAS: call at 0x10, then call at 0x20; `pred_ret` twice returns 0x24 then 0x14, src 2. A third `pred_ret` with `pred_taken` = 0 gives sequential, src 0.
- RAS overflow with `RAS_DEPTH` = 4: 5 calls, then 5 returns. Returns yield the last 4 return addresses newest first; the 5th return falls through to sequential. Redirect after pushes empties the RAS.
- Wrap-around and async reset: fire at 0xFFFFFFFC gives 0x0. Dropping `rst_n` mid-cycle clears `fetch_valid` before the next edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: fetch source encodings and
// the default sequential step.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        SRC_SEQ   = 2'd0,
        SRC_PRED  = 2'd1,
        SRC_RAS   = 2'd2,
        SRC_REDIR = 2'd3
    } fetch_src_e;

    localparam int DEF_INST_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pop-then-push when both are requested,
// push while full overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  ptr_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];

    logic             do_pop;
    logic [PTR_W-1:0] pop_ptr;

    assign empty   = (cnt_p0 == '0);
    assign do_pop  = pop & ~empty;
    assign pop_ptr = do_pop ? ptr_p0 - PTR_W'(1) : ptr_p0;
    assign top     = mem[ptr_p0 - PTR_W'(1)];

    // ---- stage p0: pointer/count (control) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p0 <= '0;
            cnt_p0 <= '0;
        end else if (clear) begin
            ptr_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            ptr_p0 <= push ? pop_ptr + PTR_W'(1) : pop_ptr;
            if (do_pop && !push)
                cnt_p0 <= cnt_p0 - CNT_W'(1);
            else if (push && !do_pop && cnt_p0 != CNT_W'(RAS_DEPTH))
                cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p0: entry storage (data, no reset) ----
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[pop_ptr] <= wdata;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: priority redirect > RAS > predictor > sequential.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = DEF_INST_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_pc,
    input  logic              pred_call,
    input  logic              pred_ret,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [1:0]        fetch_src
);

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(INST_BYTES - 1);
    endfunction

    logic              vld_p0;
    logic [ADDR_W-1:0] pc_p0;
    fetch_src_e        src_p0;

    logic              vld_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    fetch_src_e        src_nxt;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_hit;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_clear;

    assign seq_pc = pc_p0 + ADDR_W'(INST_BYTES);

`ifdef PC_GEN_RAS_EN
    logic ras_empty;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .clear (ras_clear),
        .wdata (seq_pc),
        .top   (ras_top),
        .empty (ras_empty)
    );

    assign ras_hit = pred_ret & ~ras_empty;
`else
    logic unused_ras;

    assign ras_top    = '0;
    assign ras_hit    = 1'b0;
    assign unused_ras = ^{pred_call, pred_ret, ras_push, ras_pop, ras_clear};
`endif

    always_comb begin
        vld_nxt   = vld_p0;
        pc_nxt    = pc_p0;
        src_nxt   = src_p0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (rdy) begin
            if (redirect_valid) begin
                vld_nxt   = 1'b1;
                pc_nxt    = align_pc(redirect_pc);
                src_nxt   = SRC_REDIR;
                ras_clear = 1'b1;
            end else if (!vld_p0) begin
                vld_nxt = 1'b1;
            end else if (fetch_ready) begin
                ras_push = pred_call;
                if (ras_hit) begin
                    pc_nxt  = ras_top;
                    src_nxt = SRC_RAS;
                    ras_pop = 1'b1;
                end else if (pred_taken) begin
                    pc_nxt  = align_pc(pred_pc);
                    src_nxt = SRC_PRED;
                end else begin
                    pc_nxt  = seq_pc;
                    src_nxt = SRC_SEQ;
                end
            end
        end
    end

    // ---- stage p0: presented fetch address ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            pc_p0  <= RESET_PC;
            src_p0 <= SRC_SEQ;
        end else begin
            vld_p0 <= vld_nxt;
            pc_p0  <= pc_nxt;
            src_p0 <= src_nxt;
        end
    end

    assign fetch_valid = vld_p0;
    assign fetch_pc    = pc_p0;
    assign fetch_src   = src_p0;

endmodule
